mux_scan_sequencer: RTL
=======================

# mux_scan_sequencer

Generates the high/medium/low mux address triplet and the mux enable that feed `mux_protect`, stepping the medium-amplitude channel across a programmed channel range. It produces a test-pulse strobe per injection and reports progress to the comparator test controller. Addresses are always mutually distinct by construction, so `mux_protect` should never veto a sequencer-driven enable. Any veto indicates an upstream fault.

## Interface
Parameters:
- `SETTLE_CYCLES`, 16: cycles mux_en is high before the first pulse on a channel (≥1).
- `PULSE_CYCLES`, 4: width of `pulse` in cycles (≥1).
- `DWELL_CYCLES`, 32: cycles after each pulse before the next step (≥1).

Ports:
- `clock`  in  1  single system clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `abort`  in  1  level; terminates the scan from any state.
- `chan_first`  in  4  first medium channel; latched at start.
- `chan_last`  in  4  last medium channel; latched at start.
- `n_pulses`  in  8  pulses per channel; 0 is treated as 1; latched at start.
- `high_adr`  out  4  equals med_adr+1 mod 16.
- `med_adr`  out  4  current channel.
- `low_adr`  out  4  equals med_adr−1 mod 16.
- `mux_en`  out  1  drives `mux_protect` mux_en_in.
- `pulse`  out  1  injection strobe.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse when the scan completes normally.
- `aborted`  out  1  one-cycle pulse when abort ends an active scan.
- `err`  out  1  one-cycle pulse when a start is rejected.

## Operation
- All outputs are registered.
- Reset values:
  - `med_adr`=0, `high_adr`=1, `low_adr`=15.
  - `mux_en`, `pulse`, `busy`, `done`, `aborted`, `err` = 0.
  - State = IDLE.
- FSM states: IDLE, SETUP, SETTLE, PULSE, DWELL, NEXT, DONE.
- IDLE:
  - On start with abort low: latch inputs, load `med_adr`=chan_first and its neighbours, go to SETUP.
  - start together with abort: ignored.
- SETUP: one cycle; `mux_en`=0 (break-before-make); then SETTLE.
- SETTLE: `mux_en`=1 for SETTLE_CYCLES; then PULSE.
- PULSE: `mux_en`=1, `pulse`=1 for PULSE_CYCLES; then DWELL.
- DWELL: `mux_en`=1, `pulse`=0 for DWELL_CYCLES; then NEXT.
- NEXT: one cycle, `mux_en`=1. Exits in priority order:
  - Repeats remain: decrement and go to PULSE (no resettle).
  - `med_adr`==chan_last: go to DONE.
  - Otherwise: `med_adr` +1 mod 16, neighbours updated in the same edge, go to SETUP.
- DONE: `done`=1, `mux_en`=0 for one cycle; then IDLE.
- Abort in any non-IDLE state:
  - Next edge: IDLE, `mux_en`=0, `pulse`=0, `aborted`=1 for one cycle, no `done`.
  - Addresses hold their last value.
- `start` while busy: ignored.
- Counters:
  - One shared 16-bit phase counter, loaded on each state entry.
  - One 8-bit repeat counter.
- `high_adr`/`low_adr` use 4-bit modular arithmetic (15+1=0, 0−1=15).

## Timing
- Start-to-SETUP latency: 1 cycle. `busy` rises on the same edge.
- Per-channel cycles: 1 + S + R·(P + D + 1), where S, P, D are the parameters and R = max(n_pulses, 1).
- Whole scan: sum over channels, plus 1 DONE cycle.
- Address change and the `mux_en` low edge coincide, at SETUP entry. `mux_en` rises one cycle later.
- `pulse` is never high while `mux_en` is low.
- `pulse` is never high in the cycle an address changes.

## Configuration
- `SCAN_WRAP_EN` defined:
  - chan_last < chan_first scans upward and wraps 15→0.
  - Example: first=14, last=1 visits 14, 15, 0, 1.
- `SCAN_WRAP_EN` undefined:
  - start with chan_last < chan_first is rejected: `err`=1 for one cycle, FSM stays IDLE, `busy` stays 0.
- chan_first == chan_last is a valid single-channel scan in both builds.

## Test plan
Parameters for all scenarios: S=4, P=2, D=3.
- Single channel (start at cycle 0, first=last=5, n=1):
  - addresses 6/5/4 from cycle 1; `mux_en` high cycles 2–11.
  - `pulse` high cycles 6–7; `done` at cycle 12; `busy` cycles 1–12.
- Repeat (first=last=9, n=3): three 2-cycle pulses 6 cycles apart; no SETUP between them; `done` at cycle 24.
- Multi-channel (first=2, last=4, n=1):
  - `med_adr` 2, 3, 4; `mux_en` low exactly one cycle at each address change.
  - `high_adr`/`med_adr`/`low_adr` never equal.
- Wrap (first=14, last=1):
  - with `SCAN_WRAP_EN`: `med_adr` 14, 15, 0, 1; `high_adr`=0 and `low_adr`=14 at channel 15; `high_adr`=1 and `low_adr`=15 at channel 0.
  - without `SCAN_WRAP_EN`: `err` pulse, `busy` stays 0.
- Abort during PULSE: next cycle `mux_en`=0, `pulse`=0, `aborted`=1, no `done`; a subsequent start runs normally.
- Reset: `reset_n` low mid-DWELL → all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mux_scan_sequencer.sv
// Scan sequencer: steps the medium mux channel across a programmed range, driving
// high/med/low addresses, mux enable and test pulses. Define SCAN_WRAP_EN to allow 15->0 wrapping scans.
module mux_scan_sequencer #(
  parameter int SETTLE_CYCLES = 16,
  parameter int PULSE_CYCLES  = 4,
  parameter int DWELL_CYCLES  = 32
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] chan_first,
  input  logic [3:0] chan_last,
  input  logic [7:0] n_pulses,
  output logic [3:0] high_adr,
  output logic [3:0] med_adr,
  output logic [3:0] low_adr,
  output logic       mux_en,
  output logic       pulse,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, SETUP, SETTLE, PULSE, DWELL, NEXT, DONE} state_t;

  localparam logic [15:0] SETTLE_LD = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] PULSE_LD  = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] DWELL_LD  = 16'(DWELL_CYCLES - 1);

  state_t      r_state;
  logic [15:0] r_phase;
  logic [7:0]  r_rep;
  logic [7:0]  r_npulses;
  logic [3:0]  r_last;
  logic [3:0]  r_med, r_high, r_low;
  logic        r_mux_en, r_pulse, r_busy, r_done, r_aborted, r_err;

  logic        w_reject;
  logic [7:0]  w_reps;
  logic [3:0]  w_med_inc;

`ifdef SCAN_WRAP_EN
  assign w_reject = 1'b0;
`else
  assign w_reject = (chan_last < chan_first);
`endif

  assign w_reps    = (n_pulses == 8'd0) ? 8'd1 : n_pulses;
  assign w_med_inc = r_med + 4'd1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_phase   <= 16'd0;
      r_rep     <= 8'd0;
      r_npulses <= 8'd1;
      r_last    <= 4'd0;
      r_med     <= 4'd0;
      r_high    <= 4'd1;
      r_low     <= 4'd15;
      r_mux_en  <= 1'b0;
      r_pulse   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_err     <= 1'b0;
      // Abort wins over every in-progress transition; addresses are left untouched.
      if (r_state != IDLE && abort) begin
        r_state   <= IDLE;
        r_mux_en  <= 1'b0;
        r_pulse   <= 1'b0;
        r_busy    <= 1'b0;
        r_aborted <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            if (start && !abort) begin
              if (w_reject) begin
                r_err <= 1'b1;
              end else begin
                r_last    <= chan_last;
                r_npulses <= w_reps;
                r_med     <= chan_first;
                r_high    <= chan_first + 4'd1;
                r_low     <= chan_first - 4'd1;
                r_mux_en  <= 1'b0;
                r_busy    <= 1'b1;
                r_state   <= SETUP;
              end
            end
          end
          SETUP: begin
            r_mux_en <= 1'b1;
            r_phase  <= SETTLE_LD;
            r_state  <= SETTLE;
          end
          SETTLE: begin
            if (r_phase == 16'd0) begin
              r_pulse <= 1'b1;
              r_phase <= PULSE_LD;
              r_rep   <= r_npulses - 8'd1;
              r_state <= PULSE;
            end else begin
              r_phase <= r_phase - 16'd1;
            end
          end
          PULSE: begin
            if (r_phase == 16'd0) begin
              r_pulse <= 1'b0;
              r_phase <= DWELL_LD;
              r_state <= DWELL;
            end else begin
              r_phase <= r_phase - 16'd1;
            end
          end
          DWELL: begin
            if (r_phase == 16'd0) begin
              r_state <= NEXT;
            end else begin
              r_phase <= r_phase - 16'd1;
            end
          end
          NEXT: begin
            // Repeats re-pulse the same channel without a new settle period.
            if (r_rep != 8'd0) begin
              r_rep   <= r_rep - 8'd1;
              r_pulse <= 1'b1;
              r_phase <= PULSE_LD;
              r_state <= PULSE;
            end else if (r_med == r_last) begin
              r_mux_en <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_med    <= w_med_inc;
              r_high   <= w_med_inc + 4'd1;
              r_low    <= r_med;
              r_mux_en <= 1'b0;
              r_state  <= SETUP;
            end
          end
          DONE: begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
          default: begin
            r_mux_en <= 1'b0;
            r_pulse  <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end
        endcase
      end
    end
  end

  assign high_adr = r_high;
  assign med_adr  = r_med;
  assign low_adr  = r_low;
  assign mux_en   = r_mux_en;
  assign pulse    = r_pulse;
  assign busy     = r_busy;
  assign done     = r_done;
  assign aborted  = r_aborted;
  assign err      = r_err;

endmodule
